// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: bus widths, PC step, fetch FSM states and
// the instruction-queue entry layout used by the fetch unit and its FIFO.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 16;

    localparam logic [ADDR_W-1:0] PC_STEP          = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = ADDR_W'(0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REQ_STALE
    } fetch_state_e;

    // One buffered fetch: the instruction word and the PC of the following slot.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_add2;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of fetch entries.
// Ports: clk, rst (async, active high); push/wdata write an entry; pop removes
// the head; flush empties the buffer and overrides push and pop in that cycle;
// head/valid present the oldest entry; count is the occupancy.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             wdata,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && valid && !flush;
    assign valid   = (count != '0);
    assign head    = mem[rd_ptr];

    // Storage and pointers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end owning the fetch PC.
// Ports: clk, rst (async, active high); mem_req/mem_addr/mem_ack/mem_rdata form
// the instruction-memory read handshake (data valid with ack); out_valid,
// out_instr, out_pc_add2 present the queue head to IF/ID and out_ready pops it;
// redirect/redirect_pc flush the queue and restart fetch; count is occupancy.
module fetch_queue_unit
    import cpu_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_W-1:0]     mem_rdata,
    output logic                   out_valid,
    output logic [INSTR_W-1:0]     out_instr,
    output logic [ADDR_W-1:0]      out_pc_add2,
    input  logic                   out_ready,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state;
    fetch_state_e      state_n;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_n;
    logic [ADDR_W-1:0] addr_n;
    logic              req_n;
    logic [ADDR_W-1:0] pc_inc;
    logic              xfer;
    logic              pop;
    logic              push;
    logic [CNT_W-1:0]  count_after;
    logic              room_after;
    fetch_entry_t      wdata;
    fetch_entry_t      head;

    assign pc_inc      = fetch_pc + PC_STEP;
    assign xfer        = mem_req && mem_ack;
    assign pop         = out_valid && out_ready;
    // Only a live request in REQ delivers data; a redirect discards it.
    assign push        = (state == REQ) && xfer && !redirect;
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);
    assign room_after  = count_after < CNT_W'(DEPTH);

    assign wdata.instr   = mem_rdata;
    assign wdata.pc_add2 = pc_inc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .flush (redirect),
        .head  (head),
        .valid (out_valid),
        .count (count)
    );

    assign out_instr   = head.instr;
    assign out_pc_add2 = head.pc_add2;

    // State, fetch PC and memory request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_addr <= RESET_PC;
            mem_req  <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            mem_addr <= addr_n;
            mem_req  <= req_n;
        end
    end

    // Next-state logic; an issued request holds its address until acked.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        addr_n     = mem_addr;
        req_n      = mem_req;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_n = redirect_pc;
                    addr_n     = redirect_pc;
                    req_n      = 1'b1;
                    state_n    = REQ;
                end else if (count < CNT_W'(DEPTH)) begin
                    addr_n  = fetch_pc;
                    req_n   = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_n = redirect_pc;
                    if (mem_ack) begin
                        addr_n = redirect_pc;
                    end else begin
                        state_n = REQ_STALE;
                    end
                end else if (mem_ack) begin
                    fetch_pc_n = pc_inc;
                    if (room_after) begin
                        addr_n = pc_inc;
                    end else begin
                        req_n   = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            REQ_STALE: begin
                if (redirect) begin
                    fetch_pc_n = redirect_pc;
                end
                // The stale response is dropped; refetch from the newest target.
                if (mem_ack) begin
                    addr_n  = redirect ? redirect_pc : fetch_pc;
                    state_n = REQ;
                end
            end
            default: begin
                req_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed stimulus with a memory
// model, expected queue entries pushed when stimulus is issued, and monitors
// that pop and compare whenever the head is consumed.
module tb_fetch_queue_unit;
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_w = 1'b1;

    logic              mem_req, mem_ack, out_valid, out_ready, redirect;
    logic [15:0]       mem_addr, mem_rdata, out_instr, out_pc_add2, redirect_pc;
    logic [2:0]        count;

    logic              w_req, w_ack, w_valid;
    logic [15:0]       w_addr, w_rdata, w_instr, w_pc;
    logic [2:0]        w_count;

    logic              ack_en, stray_ack;
    logic [15:0]       slow_addr;
    int unsigned       slow_delay, wait_cnt;

    int passed = 0;
    int total  = 0;

    fetch_entry_t exp_q[$];
    fetch_entry_t exp_w[$];

    always #5 clk = ~clk;

    fetch_queue_unit #(.DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_instr(out_instr), .out_pc_add2(out_pc_add2), .out_ready(out_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .count(count)
    );

    fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(16'hFFFC)) u_wrap (
        .clk(clk), .rst(rst_w), .mem_req(w_req), .mem_addr(w_addr),
        .mem_ack(w_ack), .mem_rdata(w_rdata), .out_valid(w_valid),
        .out_instr(w_instr), .out_pc_add2(w_pc), .out_ready(1'b1),
        .redirect(1'b0), .redirect_pc(16'h0000), .count(w_count)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic fetch_entry_t make_entry(input logic [15:0] a);
        fetch_entry_t e;
        e.instr   = mem_word(a);
        e.pc_add2 = a + 16'd2;
        return e;
    endfunction

    function automatic void push_main(input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(make_entry(start + 16'(2 * i)));
    endfunction

    // Memory model: zero-wait except slow_addr, which waits slow_delay cycles.
    assign mem_rdata = mem_word(mem_addr);
    assign mem_ack   = stray_ack ||
                       (mem_req && ack_en && (mem_addr != slow_addr || wait_cnt >= slow_delay));
    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    assign w_ack   = w_req;
    assign w_rdata = mem_word(w_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Main scoreboard: a pop in a redirect cycle is void and not compared.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL pop_unexpected: got pop pc_add2 %h expected no pop", out_pc_add2);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                check("pop_instr", 32'(out_instr), 32'(e.instr));
                check("pop_pc_add2", 32'(out_pc_add2), 32'(e.pc_add2));
            end
        end
    end

    // Wrap-around scoreboard for the RESET_PC=FFFC instance.
    always @(negedge clk) begin
        if (!rst_w && w_valid && exp_w.size() != 0) begin
            fetch_entry_t e;
            e = exp_w.pop_front();
            check("wrap_instr", 32'(w_instr), 32'(e.instr));
            check("wrap_pc_add2", 32'(w_pc), 32'(e.pc_add2));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        ack_en      = 1'b1;
        stray_ack   = 1'b0;
        slow_addr   = 16'hFFFF;
        slow_delay  = 0;
        exp_w.push_back(make_entry(16'hFFFC));
        exp_w.push_back(make_entry(16'hFFFE));
        exp_w.push_back(make_entry(16'h0000));
        exp_w.push_back(make_entry(16'h0002));

        // Reset state
        #2;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0000);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", 32'(out_instr), 32'h0000);
        check("rst_out_pc_add2", 32'(out_pc_add2), 32'h0000);

        // Free-running fetch with zero-wait memory
        push_main(16'h0000, 16);
        @(negedge clk);
        rst   = 1'b0;
        rst_w = 1'b0;
        tick();
        check("t1_req", 32'(mem_req), 32'd1);
        check("t1_addr0", 32'(mem_addr), 32'h0000);
        check("t1_valid_lat", 32'(out_valid), 32'd0);
        check("wrap_addr0", 32'(w_addr), 32'hFFFC);
        tick();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_pc2", 32'(out_pc_add2), 32'h0002);
        check("t1_addr1", 32'(mem_addr), 32'h0002);
        check("wrap_addr1", 32'(w_addr), 32'hFFFE);
        tick();
        check("t1_addr2", 32'(mem_addr), 32'h0004);
        check("t1_pc4", 32'(out_pc_add2), 32'h0004);
        check("t1_count", 32'(count), 32'd1);
        check("wrap_addr2", 32'(w_addr), 32'h0000);
        repeat (4) tick();

        // Fill to full with the consumer stalled, then release one entry
        out_ready = 1'b0;
        do_reset();
        push_main(16'h0000, 16);
        repeat (5) tick();
        check("t2_full_count", 32'(count), 32'd4);
        check("t2_full_req", 32'(mem_req), 32'd0);
        repeat (2) tick();
        check("t2_hold_count", 32'(count), 32'd4);
        check("t2_hold_req", 32'(mem_req), 32'd0);
        check("t2_head_pc2", 32'(out_pc_add2), 32'h0002);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_pop_count", 32'(count), 32'd3);
        check("t2_pop_req", 32'(mem_req), 32'd0);
        tick();
        check("t2_refetch_req", 32'(mem_req), 32'd1);
        check("t2_refetch_addr", 32'(mem_addr), 32'h0008);
        tick();
        check("t2_refull", 32'(count), 32'd4);

        // Redirect while a slow request is outstanding
        out_ready  = 1'b1;
        slow_addr  = 16'h0004;
        slow_delay = 3;
        do_reset();
        push_main(16'h0000, 2);
        repeat (4) tick();
        check("t3_wait_addr", 32'(mem_addr), 32'h0004);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        exp_q.delete();
        push_main(16'h0040, 16);
        tick();
        redirect = 1'b0;
        check("t3_stale_addr", 32'(mem_addr), 32'h0004);
        check("t3_stale_count", 32'(count), 32'd0);
        tick();
        check("t3_stale_req", 32'(mem_req), 32'd1);
        check("t3_stale_addr2", 32'(mem_addr), 32'h0004);
        tick();
        check("t3_new_addr", 32'(mem_addr), 32'h0040);
        check("t3_empty", 32'(out_valid), 32'd0);
        tick();
        check("t3_new_valid", 32'(out_valid), 32'd1);
        check("t3_new_pc2", 32'(out_pc_add2), 32'h0042);
        repeat (3) tick();
        slow_addr = 16'hFFFF;

        // Redirect coinciding with an ack and a pop
        do_reset();
        push_main(16'h0000, 4);
        repeat (2) tick();
        check("t4_pre_count", 32'(count), 32'd1);
        check("t4_pre_addr", 32'(mem_addr), 32'h0002);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        exp_q.delete();
        push_main(16'h0100, 16);
        tick();
        redirect = 1'b0;
        check("t4_count", 32'(count), 32'd0);
        check("t4_valid", 32'(out_valid), 32'd0);
        check("t4_req", 32'(mem_req), 32'd1);
        check("t4_addr", 32'(mem_addr), 32'h0100);
        tick();
        check("t4_new_pc2", 32'(out_pc_add2), 32'h0102);
        repeat (3) tick();

        // Reset asserted mid-request, stray ack after release
        out_ready = 1'b0;
        do_reset();
        push_main(16'h0000, 4);
        repeat (3) tick();
        check("t6_pre_count", 32'(count), 32'd2);
        check("t6_pre_req", 32'(mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_req", 32'(mem_req), 32'd0);
        check("t6_rst_addr", 32'(mem_addr), 32'h0000);
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_instr", 32'(out_instr), 32'h0000);
        check("t6_rst_pc2", 32'(out_pc_add2), 32'h0000);
        exp_q.delete();
        push_main(16'h0000, 4);
        ack_en    = 1'b0;
        stray_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        stray_ack = 1'b0;
        ack_en    = 1'b1;
        check("t6_first_req", 32'(mem_req), 32'd1);
        check("t6_first_addr", 32'(mem_addr), 32'h0000);
        check("t6_stray_ignored", 32'(count), 32'd0);
        tick();
        check("t6_count", 32'(count), 32'd1);
        check("t6_instr", 32'(out_instr), 32'h5A5A);
        check("t6_pc2", 32'(out_pc_add2), 32'h0002);
        out_ready = 1'b1;
        repeat (3) tick();

        check("wrap_all_popped", 32'(exp_w.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register and owns the fetch PC.
- Issues 16-bit instruction reads to instruction memory over a req/ack handshake and buffers the returned words with their PC+2 values in a small FIFO.
- Presents the FIFO head to IF/ID. It honours the hazard unit's stall through out_ready, and flushes/redirects on a taken branch or jump from the branch logic.

Parameters:
- DEPTH, 4, FIFO entries; a power of two, at least 2.
- ADDR_W, 16, PC and memory address width.
- INSTR_W, 16, instruction width.
- RESET_PC, 16'h0000, fetch PC after reset.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous active-high reset.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  read address; stable while mem_req=1.
- mem_ack  in  1  request accepted; mem_rdata valid in the same cycle.
- mem_rdata  in  INSTR_W  instruction word.
- out_valid  out  1  FIFO head valid.
- out_instr  out  INSTR_W  head instruction, driven into the IF/ID instr input.
- out_pc_add2  out  ADDR_W  head PC+2, driven into the IF/ID pc input.
- out_ready  in  1  consumer accepts the head; tied to IFIDWrite.
- redirect  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  ADDR_W  new fetch target.
- count  out  clog2(DEPTH)+1  FIFO occupancy, for debug and coverage.

Behaviour:
- Reset (async, rst=1), applied immediately, including mid-transaction:
  - mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC.
  - FIFO empty: count=0, out_valid=0, out_instr=0, out_pc_add2=0.
  - state=IDLE; any in-flight response is forgotten.
- Handshake and transfer rules:
  - A memory transfer occurs at a rising edge with mem_req && mem_ack.
  - A pop occurs at a rising edge with out_valid && out_ready.
- At most one outstanding request.
- While mem_req=1, mem_addr and mem_req hold until ack; a request is never withdrawn.
- FSM states: IDLE, REQ, REQ_STALE.
- IDLE:
  - If count<DEPTH, go to REQ next cycle with mem_req=1 and mem_addr=fetch_pc.
  - Otherwise stay in IDLE.
- REQ, on ack:
  - Push {mem_rdata, fetch_pc+2} and set fetch_pc+=2.
  - If the FIFO still has room after this cycle's push and pop, stay in REQ with the next address (back-to-back, one word per cycle with a zero-wait memory).
  - Otherwise go to IDLE.
- Full check: count cannot rise while a request is outstanding, so raising mem_req at count<DEPTH guarantees a free slot at ack.
- PC arithmetic is modulo 2^ADDR_W; 16'hFFFE+2 = 16'h0000.
- Latency:
  - ack to out_valid is 1 cycle when the FIFO was empty (no combinational bypass).
  - Reset deassertion to first mem_req is 1 cycle.
- Simultaneous push and pop when full is impossible (no request is issued at full). When not full, push and pop in one cycle leave count unchanged.
- Redirect (takes priority over everything):
  - FIFO flushed at that edge: count=0, out_valid=0 next cycle; a same-cycle pop is void.
  - fetch_pc=redirect_pc.
  - If no request is outstanding, or the outstanding request is acked in the same cycle (its data is discarded), the next state is REQ at redirect_pc.
  - If a request is outstanding and not acked, go to REQ_STALE. mem_addr keeps the old address.
- REQ_STALE:
  - On ack, drop the data (no push) and go to REQ at fetch_pc next cycle.
  - A further redirect in REQ_STALE only updates fetch_pc.
- out_ready=0 only holds the head; fetching continues until the FIFO is full.

Decomposition:
- Shared package cpu_pkg, holding:
  - ADDR_W=16, INSTR_W=16, PC_STEP=2, RESET_PC.
  - The fetch state enum {IDLE, REQ, REQ_STALE}.
  - The instruction-entry struct {instr, pc_add2}.
- One sub-module, fetch_fifo:
  - DEPTH-entry circular buffer with push, pop and synchronous flush (flush wins over push and pop).
  - Pointer wrap at DEPTH.
  - count output.
- The top-level block holds the FSM and fetch_pc.

Test Plan:
- Reset, then memory acks every cycle and out_ready=1 -> mem_addr sequence 0000,0002,0004...; out_pc_add2 = 0002,0004...; first out_valid 2 cycles after reset release.
- out_ready=0 with a zero-wait memory -> exactly 4 pushes (addresses 0000-0006), count=4, mem_req=0. Raise out_ready for 1 cycle -> count=3, then a new req at 0008.
- Ack delayed 3 cycles at addr 0004, redirect to 0040 in the second wait cycle -> mem_addr stays 0004 until ack, word discarded, next req at 0040, FIFO empty until 0040's word arrives.
- redirect with mem_ack and pop in the same cycle -> count=0 next cycle, acked word not pushed, mem_req at redirect_pc.
- RESET_PC=16'hFFFC, free-running -> addresses FFFC, FFFE, 0000; out_pc_add2 FFFE, 0000, 0002.
- Assert rst while in REQ with count=2 -> outputs reset immediately, mem_req=0. A stale mem_ack after release is ignored, and the first req is at RESET_PC.
